// File: rtl/ekf_matrix_mem.sv
// EKF state/matrix RAM: one write port, NUM_RD registered read ports, and a
// sweep engine that zeroes the array and seeds the covariance diagonal.
module ekf_matrix_mem #(
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int DIAG_BASE  = 16,
    parameter int DIAG_DIM   = 4,
    parameter logic [DATA_WIDTH-1:0] DIAG_VAL = DATA_WIDTH'(32'h0001_0000)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_start,
    output logic                           init_busy,
    output logic                           init_done,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           wr_ready,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_valid,
    output logic                           addr_err
);

    localparam int DIAG_END = DIAG_BASE + DIAG_DIM * DIAG_DIM;
    localparam int STEP_W   = (DIAG_DIM > 0) ? $clog2(DIAG_DIM + 1) : 1;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_sweep_addr;
    logic [STEP_W-1:0]       r_diag_step;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_SIZE];

    logic                    w_idle;
    logic                    w_in_diag;
    logic                    w_diag_hit;
    logic                    w_sweep_last;
    logic                    w_wr_oob;
    logic                    w_wr_ok;
    logic                    w_oob_hit;
    logic [ADDR_WIDTH-1:0]   w_rd_addr [NUM_RD];
    logic [NUM_RD-1:0]       w_rd_oob;
    logic [NUM_RD-1:0]       w_rd_acc;
    logic [DATA_WIDTH-1:0]   w_rd_word [NUM_RD];
    logic [NUM_RD-1:0]       r_rd_valid;
    logic [NUM_RD*DATA_WIDTH-1:0] r_rd_data;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_in_diag    = (32'(r_sweep_addr) >= DIAG_BASE) && (32'(r_sweep_addr) < DIAG_END);
    // Step counter returns to zero every DIAG_DIM+1 words inside the covariance block.
    assign w_diag_hit   = w_in_diag && (r_diag_step == '0);
    assign w_sweep_last = (r_sweep_addr == ADDR_WIDTH'(MEM_SIZE - 1));
    assign w_wr_oob     = (32'(wr_addr) >= MEM_SIZE);
    assign w_wr_ok      = w_idle && wr_en && !w_wr_oob;
    assign w_oob_hit    = (w_idle && wr_en && w_wr_oob) || |(w_rd_acc & w_rd_oob);

    assign init_busy = r_busy;
    assign init_done = r_done;
    assign wr_ready  = !r_busy;
    assign addr_err  = r_err;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_sweep_addr <= '0;
            r_diag_step  <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_done <= 1'b0;
                    if (w_in_diag) begin
                        r_diag_step <= (r_diag_step == STEP_W'(DIAG_DIM)) ? '0 : r_diag_step + 1'b1;
                    end
                    if (w_sweep_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (w_oob_hit) begin
                        r_err <= 1'b1;
                    end
                    if (init_start) begin
                        r_state      <= ST_INIT;
                        r_busy       <= 1'b1;
                        r_sweep_addr <= '0;
                        r_diag_step  <= '0;
                        r_err        <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!w_idle) begin
            r_mem[r_sweep_addr] <= w_diag_hit ? DIAG_VAL : '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_addr[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_rd_oob[i]  = (32'(w_rd_addr[i]) >= MEM_SIZE);
            w_rd_acc[i]  = rd_en[i] && w_idle;
            if (w_rd_oob[i]) begin
                w_rd_word[i] = '0;
            end else if ((RDW_MODE == 1) && w_wr_ok && (wr_addr == w_rd_addr[i])) begin
                w_rd_word[i] = wr_data;
            end else begin
                w_rd_word[i] = r_mem[w_rd_addr[i]];
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            // stage p0: array read lands directly in the output register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_valid <= '0;
                    r_rd_data  <= '0;
                end else begin
                    for (int i = 0; i < NUM_RD; i++) begin
                        r_rd_valid[i] <= w_rd_acc[i];
                        if (w_rd_acc[i]) begin
                            r_rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_rd_word[i];
                        end
                    end
                end
            end
        end else if (RD_LATENCY == 2) begin : g_lat2
            logic [NUM_RD-1:0]     r_vld_p0;
            logic [DATA_WIDTH-1:0] r_data_p0 [NUM_RD];

            // stage p0: array read captured
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_p0 <= '0;
                end else begin
                    r_vld_p0 <= w_rd_acc;
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < NUM_RD; i++) begin
                    r_data_p0[i] <= w_rd_word[i];
                end
            end

            // stage p1: output register, holds while no valid arrives
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_valid <= '0;
                    r_rd_data  <= '0;
                end else begin
                    for (int i = 0; i < NUM_RD; i++) begin
                        r_rd_valid[i] <= r_vld_p0[i];
                        if (r_vld_p0[i]) begin
                            r_rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= r_data_p0[i];
                        end
                    end
                end
            end
        end else begin : g_bad_lat
            $error("ekf_matrix_mem: RD_LATENCY must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_ekf_matrix_mem.sv
// Bench for ekf_matrix_mem: three configurations share one stimulus stream and
// are checked every cycle against a behavioural model plus literal expectations.
module tb_ekf_matrix_mem;

    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  rd_en = '0;
    logic [11:0] rd_addr = '0;

    logic        busy [3];
    logic        done [3];
    logic        wrdy [3];
    logic        err  [3];
    logic [1:0]  rv   [3];
    logic [63:0] rd   [3];

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    // A: 64 words, latency 1, old-data; B: 64 words, latency 2, bypass; C: 48 words.
    ekf_matrix_mem #(.MEM_SIZE(64), .DATA_WIDTH(32), .NUM_RD(2), .RD_LATENCY(1), .RDW_MODE(0),
                     .DIAG_BASE(16), .DIAG_DIM(4), .DIAG_VAL(ONE)) u_a (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy[0]), .init_done(done[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrdy[0]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd[0]), .rd_valid(rv[0]), .addr_err(err[0]));

    ekf_matrix_mem #(.MEM_SIZE(64), .DATA_WIDTH(32), .NUM_RD(2), .RD_LATENCY(2), .RDW_MODE(1),
                     .DIAG_BASE(16), .DIAG_DIM(4), .DIAG_VAL(ONE)) u_b (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy[1]), .init_done(done[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrdy[1]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd[1]), .rd_valid(rv[1]), .addr_err(err[1]));

    ekf_matrix_mem #(.MEM_SIZE(48), .DATA_WIDTH(32), .NUM_RD(2), .RD_LATENCY(1), .RDW_MODE(0),
                     .DIAG_BASE(16), .DIAG_DIM(4), .DIAG_VAL(ONE)) u_c (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy[2]), .init_done(done[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrdy[2]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd[2]), .rd_valid(rv[2]), .addr_err(err[2]));

    function automatic int ms_of(int k);
        return (k == 2) ? 48 : 64;
    endfunction

    function automatic int lat_of(int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic bit rdw_of(int k);
        return (k == 1);
    endfunction

    function automatic logic [31:0] diag_word(int a);
        if (a >= 16 && a < 32 && ((a - 16) % 5) == 0) return ONE;
        return 32'h0;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", name, k, $time, act, exp);
        end
    endtask

    // Behavioural model: memory image, sweep progress and pending read results.
    logic [31:0] m_mem  [3][64];
    bit          m_busy [3];
    bit          m_done [3];
    bit          m_err  [3];
    int          m_sweep[3];
    bit          m_rv   [3][2];
    logic [31:0] m_rd   [3][2];
    bit          m_pv   [3][2];
    logic [31:0] m_pd   [3][2];

    initial begin
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 64; a++) m_mem[k][a] = 32'h0;
    end

    always @(posedge clk) begin : model
        bit wacc, oob, acc;
        int ra;
        logic [31:0] val;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] = 1; m_sweep[k] = 0; m_done[k] = 0; m_err[k] = 0;
                for (int p = 0; p < 2; p++) begin
                    m_rv[k][p] = 0; m_rd[k][p] = 0; m_pv[k][p] = 0;
                end
            end else begin
                wacc = !m_busy[k] && wr_en && (int'(wr_addr) < ms_of(k));
                oob  = !m_busy[k] && wr_en && (int'(wr_addr) >= ms_of(k));
                for (int p = 0; p < 2; p++) begin
                    ra  = int'(rd_addr[p*6 +: 6]);
                    acc = rd_en[p] && !m_busy[k];
                    if (ra >= ms_of(k)) val = 32'h0;
                    else if (rdw_of(k) && wacc && int'(wr_addr) == ra) val = wr_data;
                    else val = m_mem[k][ra];
                    if (acc && ra >= ms_of(k)) oob = 1;
                    if (lat_of(k) == 1) begin
                        m_rv[k][p] = acc;
                        if (acc) m_rd[k][p] = val;
                    end else begin
                        m_rv[k][p] = m_pv[k][p];
                        if (m_pv[k][p]) m_rd[k][p] = m_pd[k][p];
                        m_pv[k][p] = acc;
                        m_pd[k][p] = val;
                    end
                end
                if (m_busy[k]) begin
                    m_mem[k][m_sweep[k]] = diag_word(m_sweep[k]);
                    m_sweep[k]++;
                    m_done[k] = 0;
                    if (m_sweep[k] == ms_of(k)) begin
                        m_busy[k] = 0;
                        m_done[k] = 1;
                    end
                end else begin
                    m_done[k] = 0;
                    if (wacc) m_mem[k][int'(wr_addr)] = wr_data;
                    if (oob) m_err[k] = 1;
                    if (init_start) begin
                        m_busy[k] = 1; m_sweep[k] = 0; m_err[k] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk("init_busy", k, 32'(busy[k]), 32'(m_busy[k]));
                chk("init_done", k, 32'(done[k]), 32'(m_done[k]));
                chk("wr_ready",  k, 32'(wrdy[k]), 32'(!m_busy[k]));
                chk("addr_err",  k, 32'(err[k]),  32'(m_err[k]));
                for (int p = 0; p < 2; p++) begin
                    chk(p == 0 ? "rd_valid0" : "rd_valid1", k, 32'(rv[k][p]), 32'(m_rv[k][p]));
                    chk(p == 0 ? "rd_data0" : "rd_data1", k, rd[k][p*32 +: 32], m_rd[k][p]);
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1; wr_addr = 6'(a); wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    // Dual-port read; A and C report one cycle later, B one cycle after that.
    task automatic rd2(input int a0, input int a1, input logic [31:0] ea0, input logic [31:0] ea1,
                       input logic [31:0] ec0, input logic [31:0] ec1);
        rd_en = 2'b11; rd_addr = {6'(a1), 6'(a0)};
        @(negedge clk);
        rd_en = 2'b00;
        chk("lit_rv_a", 0, 32'(rv[0]), 32'h3);
        chk("lit_rd0_a", 0, rd[0][31:0], ea0);
        chk("lit_rd1_a", 0, rd[0][63:32], ea1);
        chk("lit_rv_c", 2, 32'(rv[2]), 32'h3);
        chk("lit_rd0_c", 2, rd[2][31:0], ec0);
        chk("lit_rd1_c", 2, rd[2][63:32], ec1);
        chk("lit_rv_b_early", 1, 32'(rv[1]), 32'h0);
        @(negedge clk);
        chk("lit_rv_b", 1, 32'(rv[1]), 32'h3);
        chk("lit_rd0_b", 1, rd[1][31:0], ea0);
        chk("lit_rd1_b", 1, rd[1][63:32], ea1);
        chk("lit_rv_a_drop", 0, 32'(rv[0]), 32'h0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 0, 32'(n >= 200), 32'h0);
    endtask

    // Counts busy/done samples for A and C over a 70-cycle window.
    task automatic sweep_window(input int exp_a, input int exp_c);
        int ba = 0, bc = 0, da = 0, dc = 0;
        for (int i = 0; i < 70; i++) begin
            ba += int'(busy[0]); bc += int'(busy[2]);
            da += int'(done[0]); dc += int'(done[2]);
            @(negedge clk);
        end
        chk("busy_cycles", 0, 32'(ba), 32'(exp_a));
        chk("busy_cycles", 2, 32'(bc), 32'(exp_c));
        chk("done_pulses", 0, 32'(da), 32'h1);
        chk("done_pulses", 2, 32'(dc), 32'h1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_on = 1;
        rst = 0;
        sweep_window(64, 48);
        rd2(16, 21, ONE, ONE, ONE, ONE);
        rd2(26, 31, ONE, ONE, ONE, ONE);
        rd2(17, 0, 0, 0, 0, 0);

        wr(5, 32'hDEADBEEF);
        rd2(5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);

        wr(7, 32'h1);
        wr_en = 1; wr_addr = 6'd7; wr_data = 32'h2;
        rd_en = 2'b01; rd_addr = {6'd0, 6'd7};
        @(negedge clk);
        wr_en = 0; rd_en = 2'b00;
        chk("rdw_old", 0, rd[0][31:0], 32'h1);
        chk("rdw_old", 2, rd[2][31:0], 32'h1);
        @(negedge clk);
        chk("rdw_new", 1, rd[1][31:0], 32'h2);
        rd2(7, 7, 32'h2, 32'h2, 32'h2, 32'h2);

        wr(50, 32'h1234);
        chk("oob_err", 2, 32'(err[2]), 32'h1);
        chk("oob_err", 0, 32'(err[0]), 32'h0);
        rd2(50, 7, 32'h1234, 32'h2, 32'h0, 32'h2);

        init_start = 1;
        @(negedge clk);
        init_start = 0;
        chk("err_clear", 2, 32'(err[2]), 32'h0);
        repeat (5) @(negedge clk);
        init_start = 1;
        @(negedge clk);
        init_start = 0;
        repeat (22) @(negedge clk);
        rst = 1;
        wr_en = 1; wr_addr = 6'd9; wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        rst = 0;
        sweep_window(64, 48);
        wr_en = 0;
        rd2(9, 5, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);

        init_start = 1;
        @(negedge clk);
        init_start = 0;
        wait_idle();
        rd2(9, 40, 0, 0, 0, 0);
        rd2(21, 16, ONE, ONE, ONE, ONE);

        for (int c = 0; c < 3000; c++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = $urandom;
            rd_en   = 2'($urandom_range(0, 3));
            rd_addr = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
            if ($urandom_range(0, 3) == 0) rd_addr[5:0] = wr_addr;
            if ($urandom_range(0, 3) == 0) rd_addr[11:6] = wr_addr;
            init_start = ($urandom_range(0, 299) == 0);
            rst        = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        wr_en = 0; rd_en = 0; init_start = 0; rst = 0;
        repeat (4) @(negedge clk);
        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
